ysyx_23060075_lsu: RTL and testbench

YSYX_23060075_LSU -- requirements
Module: ysyx_23060075_lsu

---
 rtl/ysyx_23060075_lsu_if.sv | 21 ++
 rtl/ysyx_23060075_lsu.sv | 152 +++++++++++++++
 tb/tb_ysyx_23060075_lsu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060075_lsu_if.sv
// Bus-side channel of the LSU. The LSU is the master and the memory or interconnect is the slave.
interface ysyx_23060075_lsu_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/ysyx_23060075_lsu.sv
// Load/store unit: converts one core memory request into a single word-aligned bus transfer, with a response timeout.
// Define YSYX_23060075_LSU_ALIGN_CHECK_EN to reject misaligned half and word accesses before they reach the bus.
module ysyx_23060075_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [3:0]  mem_mask,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    ysyx_23060075_lsu_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    // The wait counter starts at 0, so the last cycle it allows is TIMEOUT_CYCLES-1.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic        zext_q, we_q;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        mem_op, misaligned, go_bus, timeout;
    logic [31:0] load_shift, load_data;
    logic        unused_funct3;

    assign unused_funct3 = ^funct3[1:0];
    assign mem_op        = mem_r_en | mem_w_en;

`ifdef YSYX_23060075_LSU_ALIGN_CHECK_EN
    assign misaligned = ((mem_mask == 4'b0011) && addr[0]) ||
                        ((mem_mask == 4'b1111) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign go_bus  = mem_op & ~misaligned;
    assign timeout = (cnt_q == LAST_WAIT);
    assign cnt_d   = (state_q == S_WAIT) ? cnt_q + 16'd1 : 16'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req_valid) state_d = go_bus ? S_REQ : S_DONE;
            S_REQ:  if (bus.bus_req_ready) state_d = S_WAIT;
            S_WAIT: if (bus.bus_resp_valid || timeout) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        bus.bus_req_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  req_ready = rst_n;
            S_REQ:   bus.bus_req_valid = 1'b1;
            S_DONE:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request fields are captured only for accesses that really go to the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            zext_q  <= 1'b0;
            we_q    <= 1'b0;
        end else if (state_q == S_IDLE && req_valid && go_bus) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            mask_q  <= mem_mask;
            zext_q  <= funct3[2];
            we_q    <= mem_w_en;
        end
    end

    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_wstrb = mask_q << addr_q[1:0];
    assign bus.bus_wdata = wdata_q << {addr_q[1:0], 3'b000};

    always_comb begin
        load_shift = bus.bus_rdata >> {addr_q[1:0], 3'b000};
        case (mask_q)
            4'b0001: load_data = {{24{~zext_q & load_shift[7]}}, load_shift[7:0]};
            4'b0011: load_data = {{16{~zext_q & load_shift[15]}}, load_shift[15:0]};
            default: load_data = load_shift;
        endcase
    end

    // Response registers change only on the transition into DONE and hold until the next one.
    always_comb begin
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            S_IDLE: if (req_valid && !go_bus) begin
                resp_rdata_d = 32'd0;
                resp_err_d   = mem_op & misaligned;
            end
            S_WAIT: if (bus.bus_resp_valid) begin
                resp_rdata_d = we_q ? 32'd0 : load_data;
                resp_err_d   = 1'b0;
            end else if (timeout) begin
                resp_rdata_d = 32'd0;
                resp_err_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_23060075_lsu.sv
// Directed bench for ysyx_23060075_lsu built with TIMEOUT_CYCLES=4; the bus slave is driven inline.
module tb_ysyx_23060075_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_r_en, mem_w_en;
    logic [3:0]  mem_mask;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_23060075_lsu_if bus_if();

    ysyx_23060075_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_mask   (mem_mask),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE with the slave answering at the first opportunity.
    task automatic run_fast(input logic r, input logic w, input logic [3:0] m, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            output int lat, output logic [31:0] got_rd, output logic got_err,
                            output logic saw_bus, output logic [31:0] bus_a, output logic [3:0] strb);
        mem_r_en = r; mem_w_en = w; mem_mask = m; funct3 = f3; addr = a; wdata = wd;
        req_valid = 1'b1;
        bus_if.bus_req_ready  = 1'b1;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = rd;
        lat = 0; saw_bus = 1'b0; bus_a = 32'd0; strb = 4'd0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            req_valid = 1'b0;
            if (bus_if.bus_req_valid) begin
                saw_bus = 1'b1;
                bus_a   = bus_if.bus_addr;
                strb    = bus_if.bus_wstrb;
            end
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        got_rd  = resp_rdata;
        got_err = resp_err;
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] got_rd, bus_a;
        logic        got_err, saw_bus;
        logic [3:0]  strb;

        rst_n = 1'b1; req_valid = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        mem_mask = 4'd0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        bus_if.bus_req_ready = 1'b0; bus_if.bus_resp_valid = 1'b0; bus_if.bus_rdata = 32'd0;

        // Reset state, before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_req_ready",  32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err",   32'(resp_err), 32'd0);
        check("rst_bus_valid",  32'(bus_if.bus_req_valid), 32'd0);
        check("rst_bus_addr",   bus_if.bus_addr, 32'd0);
        check("rst_bus_wstrb",  32'(bus_if.bus_wstrb), 32'd0);
        check("rst_bus_we",     32'(bus_if.bus_we), 32'd0);
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        #1 check("release_req_ready", 32'(req_ready), 32'd1);
        tick();

        // Signed byte load from the top lane
        mem_r_en = 1'b1; mem_mask = 4'b0001; funct3 = 3'b000; addr = 32'h8000_0003;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("lb_req_ready_busy", 32'(req_ready), 32'd0);
        check("lb_bus_valid", 32'(bus_if.bus_req_valid), 32'd1);
        check("lb_bus_addr",  bus_if.bus_addr, 32'h8000_0000);
        check("lb_bus_wstrb", 32'(bus_if.bus_wstrb), 32'b1000);
        check("lb_bus_we",    32'(bus_if.bus_we), 32'd0);
        bus_if.bus_req_ready = 1'b1;
        tick();
        bus_if.bus_req_ready  = 1'b0;
        check("lb_wait_no_bus_valid", 32'(bus_if.bus_req_valid), 32'd0);
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = 32'h8000_0000;
        tick();
        bus_if.bus_resp_valid = 1'b0;
        check("lb_resp_valid", 32'(resp_valid), 32'd1);
        check("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
        check("lb_resp_err",   32'(resp_err), 32'd0);
        tick();
        check("lb_pulse_one_cycle", 32'(resp_valid), 32'd0);
        check("lb_rdata_held",      resp_rdata, 32'hFFFF_FF80);
        check("lb_back_idle",       32'(req_ready), 32'd1);

        // Unsigned half load, minimum latency
        run_fast(1'b1, 1'b0, 4'b0011, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_1234,
                 lat, got_rd, got_err, saw_bus, bus_a, strb);
        check("lhu_latency", 32'(lat), 32'd3);
        check("lhu_rdata",   got_rd, 32'h0000_BEEF);
        check("lhu_wstrb",   32'(strb), 32'b1100);

        // Signed half load and word load
        run_fast(1'b1, 1'b0, 4'b0011, 3'b001, 32'h8000_0002, 32'd0, 32'h8001_0000,
                 lat, got_rd, got_err, saw_bus, bus_a, strb);
        check("lh_rdata", got_rd, 32'hFFFF_8001);
        run_fast(1'b1, 1'b0, 4'b1111, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF,
                 lat, got_rd, got_err, saw_bus, bus_a, strb);
        check("lw_rdata",    got_rd, 32'hDEAD_BEEF);
        check("lw_bus_addr", bus_a, 32'h8000_0004);

        // Store byte with a slow slave; fields must stay put while waiting
        mem_w_en = 1'b1; mem_mask = 4'b0001; addr = 32'h8000_0001; wdata = 32'h0000_00AB;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; mem_w_en = 1'b0; addr = 32'h1234_5677; wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            check("sb_bus_valid", 32'(bus_if.bus_req_valid), 32'd1);
            check("sb_bus_we",    32'(bus_if.bus_we), 32'd1);
            check("sb_bus_wstrb", 32'(bus_if.bus_wstrb), 32'b0010);
            check("sb_bus_wdata", bus_if.bus_wdata, 32'h0000_AB00);
            check("sb_bus_addr",  bus_if.bus_addr, 32'h8000_0000);
            tick();
        end
        bus_if.bus_req_ready = 1'b1;
        tick();
        bus_if.bus_req_ready  = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = 32'hFFFF_FFFF;
        tick();
        bus_if.bus_resp_valid = 1'b0;
        check("sb_resp_valid", 32'(resp_valid), 32'd1);
        check("sb_resp_rdata", resp_rdata, 32'd0);
        tick();

        // Both enables set: the store wins
        mem_r_en = 1'b1; mem_w_en = 1'b1; mem_mask = 4'b1111; addr = 32'h8000_0010; wdata = 32'h1234_5678;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        check("both_bus_we",    32'(bus_if.bus_we), 32'd1);
        check("both_bus_wdata", bus_if.bus_wdata, 32'h1234_5678);
        check("both_bus_wstrb", 32'(bus_if.bus_wstrb), 32'b1111);
        bus_if.bus_req_ready = 1'b1;
        tick();
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_if.bus_resp_valid = 1'b0;
        check("both_resp_rdata", resp_rdata, 32'd0);
        tick();

        // Request without any enable finishes straight away with zero data
        run_fast(1'b1, 1'b0, 4'b1111, 3'b010, 32'h8000_0020, 32'd0, 32'h5555_AAAA,
                 lat, got_rd, got_err, saw_bus, bus_a, strb);
        check("seed_rdata", got_rd, 32'h5555_AAAA);
        run_fast(1'b0, 1'b0, 4'b1111, 3'b010, 32'h8000_0020, 32'd0, 32'h5555_AAAA,
                 lat, got_rd, got_err, saw_bus, bus_a, strb);
        check("noen_latency", 32'(lat), 32'd1);
        check("noen_rdata",   got_rd, 32'd0);
        check("noen_err",     32'(got_err), 32'd0);
        check("noen_no_bus",  32'(saw_bus), 32'd0);

        // Misaligned word load
        run_fast(1'b1, 1'b0, 4'b1111, 3'b010, 32'h8000_0002, 32'd0, 32'hAABB_CCDD,
                 lat, got_rd, got_err, saw_bus, bus_a, strb);
`ifdef YSYX_23060075_LSU_ALIGN_CHECK_EN
        check("mis_err",     32'(got_err), 32'd1);
        check("mis_rdata",   got_rd, 32'd0);
        check("mis_no_bus",  32'(saw_bus), 32'd0);
        check("mis_latency", 32'(lat), 32'd1);
`else
        check("mis_bus_issued", 32'(saw_bus), 32'd1);
        check("mis_bus_addr",   bus_a, 32'h8000_0000);
        check("mis_wstrb",      32'(strb), 32'b1100);
        check("mis_rdata",      got_rd, 32'h0000_AABB);
        check("mis_err",        32'(got_err), 32'd0);
`endif

        // Timeout after four WAIT cycles, then a back-to-back request
        mem_r_en = 1'b1; mem_mask = 4'b1111; funct3 = 3'b010; addr = 32'h8000_0008;
        req_valid = 1'b1; bus_if.bus_req_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        bus_if.bus_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_wait_no_resp", 32'(resp_valid), 32'd0);
            tick();
        end
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_err",   32'(resp_err), 32'd1);
        check("to_resp_rdata", resp_rdata, 32'd0);
        addr = 32'h8000_000C; req_valid = 1'b1;
        tick();
        check("b2b_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; mem_r_en = 1'b0;
        check("b2b_bus_valid", 32'(bus_if.bus_req_valid), 32'd1);
        check("b2b_bus_addr",  bus_if.bus_addr, 32'h8000_000C);

        // Reset during WAIT, then a late response
        bus_if.bus_req_ready = 1'b1;
        tick();
        bus_if.bus_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready",  32'(req_ready), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_err",   32'(resp_err), 32'd0);
        check("mid_rst_bus_addr",   bus_if.bus_addr, 32'd0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        #1 check("mid_rst_release_ready", 32'(req_ready), 32'd1);
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_resp_ignored", 32'(resp_valid), 32'd0);
            check("late_resp_idle",    32'(req_ready), 32'd1);
        end
        bus_if.bus_resp_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
